// File: rtl/clock_ce_gen_pkg.sv
// Shared definitions for the fractional clock-enable generator.
//   state_e   : start-up sequencer states (idle, settle count, run)
//   cnt_width : width of the settle counter for a given settle length
package clock_ce_gen_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StRun    = 2'd2
  } state_e;

  // The counter only has to reach settle-1; keep at least one bit.
  function automatic int unsigned cnt_width(int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/clock_ce_gen_nco.sv
// One fractional clock-enable channel: ratio latch, phase accumulator,
// compare/subtract and the registered enable.
//   clock : master clock
//   reset : asynchronous active-low reset
//   run   : sequencer is in RUN and stays there on this edge
//   clr   : restart the phase and take new ratios (load pulse)
//   inc   : ratio numerator
//   mod   : ratio denominator
//   ce    : one-cycle enable, average rate inc/mod of clock
module clock_ce_gen_nco
  import clock_ce_gen_pkg::*;
#(
  parameter int unsigned ACCW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            clr,
  input  logic [ACCW-1:0] inc,
  input  logic [ACCW-1:0] mod,
  output logic            ce
);

  logic [ACCW-1:0] inc_q, mod_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            ce_q, ce_d;
  logic [ACCW:0]   sum;

  always_comb begin
    // One extra bit so acc + inc never wraps before the compare.
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d = '0;
    ce_d  = 1'b0;
    if (run && !clr) begin
      if (mod_q != '0) begin
        if (inc_q >= mod_q) begin
          // Rate saturates at one pulse per cycle; the phase stays at zero.
          ce_d = 1'b1;
        end else if (sum >= {1'b0, mod_q}) begin
          ce_d  = 1'b1;
          acc_d = ACCW'(sum - {1'b0, mod_q});
        end else begin
          acc_d = sum[ACCW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inc_q <= '0;
      mod_q <= '0;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
      // Ratios track the inputs until RUN; in RUN only a load replaces them.
      if (!run || clr) begin
        inc_q <= inc;
        mod_q <= mod;
      end
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clock_ce_gen.sv
// Multi-channel fractional clock-enable generator with PLL start-up sequencing.
// Waits for a synchronised PLL lock held for SETTLE cycles, then raises ready
// and lets each channel emit one-cycle enables at rate inc/mod of the clock.
//   clock  : master clock
//   reset  : asynchronous active-low reset
//   locked : PLL lock, asynchronous to clock
//   load   : pulse, latch new ratios and restart all phases
//   inc    : per-channel numerators, channel k at [k*ACCW +: ACCW]
//   mod    : per-channel denominators, same packing
//   ready  : high while running
//   ce     : per-channel clock enables
module clock_ce_gen
  import clock_ce_gen_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACCW     = 16,
  parameter int unsigned SETTLE   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     locked,
  input  logic                     load,
  input  logic [CHANNELS*ACCW-1:0] inc,
  input  logic [CHANNELS*ACCW-1:0] mod,
  output logic                     ready,
  output logic [CHANNELS-1:0]      ce
);

  localparam int unsigned CntW = cnt_width(SETTLE);

  logic            lk_meta_q, lk_s_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q;
  logic            run_keep;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (lk_s_q) state_d = StSettle;
      end
      StSettle: begin
        if (!lk_s_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(SETTLE - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lk_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Channels only advance on edges that keep us in RUN, so losing lock
  // clears ce on the same edge that clears ready.
  assign run_keep = (state_q == StRun) && lk_s_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_s_q    <= lk_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == StRun);
    end
  end

  assign ready = ready_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clock_ce_gen_nco #(
      .ACCW(ACCW)
    ) u_nco (
      .clock(clock),
      .reset(reset),
      .run  (run_keep),
      .clr  (load),
      .inc  (inc[k*ACCW +: ACCW]),
      .mod  (mod[k*ACCW +: ACCW]),
      .ce   (ce[k])
    );
  end

endmodule

// File: tb/tb_clock_ce_gen.sv
module tb_clock_ce_gen;
  localparam int unsigned Ch = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned St = 16;

  logic            clock  = 1'b0;
  logic            reset  = 1'b0;
  logic            locked = 1'b0;
  logic            load   = 1'b0;
  logic [Ch*W-1:0] inc    = '0;
  logic [Ch*W-1:0] mod    = '0;
  logic            ready;
  logic [Ch-1:0]   ce;

  int checks = 0;
  int errors = 0;

  clock_ce_gen #(
    .CHANNELS(Ch),
    .ACCW    (W),
    .SETTLE  (St)
  ) dut (
    .clock (clock),
    .reset (reset),
    .locked(locked),
    .load  (load),
    .inc   (inc),
    .mod   (mod),
    .ready (ready),
    .ce    (ce)
  );

  always #5 clock = ~clock;

  // Reference model: ready once the synchronised lock has been seen high on
  // SETTLE+1 consecutive edges; a channel n cycles into its phase pulses when
  // floor(n*inc/mod) steps up.
  logic [Ch:0] exp_q[$];
  logic [1:0]  m_lk;
  int          m_streak;
  bit          m_rdy;
  longint      m_n[Ch];
  longint      m_inc[Ch];
  longint      m_mod[Ch];

  function automatic bit crossing(longint n, longint i, longint m);
    if (m == 0) return 1'b0;
    if (i >= m) return 1'b1;
    return ((n * i) / m) != (((n - 1) * i) / m);
  endfunction

  always @(posedge clock) begin
    logic [Ch:0] e;
    bit          nrdy;
    e = '0;
    if (!reset) begin
      m_lk     = '0;
      m_streak = 0;
      m_rdy    = 1'b0;
      for (int k = 0; k < Ch; k++) begin
        m_n[k]   = 0;
        m_inc[k] = 0;
        m_mod[k] = 0;
      end
    end else begin
      if (m_lk[1]) begin
        if (m_streak <= int'(St)) m_streak = m_streak + 1;
      end else begin
        m_streak = 0;
      end
      nrdy  = (m_streak >= int'(St) + 1);
      e[Ch] = nrdy;
      for (int k = 0; k < Ch; k++) begin
        if (m_rdy && nrdy && !load) begin
          m_n[k] = m_n[k] + 1;
          e[k]   = crossing(m_n[k], m_inc[k], m_mod[k]);
        end else begin
          m_n[k] = 0;
        end
        if (!m_rdy || load) begin
          m_inc[k] = longint'(inc[k*W +: W]);
          m_mod[k] = longint'(mod[k*W +: W]);
        end
      end
      m_rdy = nrdy;
      m_lk  = {m_lk[0], locked};
    end
    exp_q.push_back(e);
  end

  always @(negedge clock) begin
    logic [Ch:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({ready, ce} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got ready=%b ce=%b, expected ready=%b ce=%b",
                 $time, ready, ce, e[Ch], e[Ch-1:0]);
      end
    end
  end

  task automatic check(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic set_ch(int c, int unsigned i, int unsigned m);
    inc[c*W +: W] = W'(i);
    mod[c*W +: W] = W'(m);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_ready(output int t);
    t = 0;
    while (!ready && t < 200) begin
      cyc(1);
      t++;
    end
  endtask

  task automatic rand_ch(int c);
    int unsigned sel, m, i;
    sel = $urandom_range(0, 7);
    case (sel)
      0: begin m = 0; i = $urandom_range(0, 20); end
      1: begin m = $urandom_range(1, 50); i = 0; end
      2: begin m = $urandom_range(1, 50); i = m; end
      3: begin m = $urandom_range(1, 50); i = m + $urandom_range(1, 20); end
      4: begin m = $urandom_range(2, 65535); i = $urandom_range(1, m - 1); end
      default: begin m = $urandom_range(2, 60); i = $urandom_range(1, m - 1); end
    endcase
    set_ch(c, i, m);
  endtask

  initial begin
    int          t, c0, c0_3k, c1, first0, last1, gapbad, act;
    logic [5:0]  pat;

    // Reset and first lock
    set_ch(0, 1, 3);
    set_ch(1, 7, 48);
    cyc(3);
    check("reset ready", ready, 0);
    check("reset ce", ce, 0);
    reset = 1'b1;
    cyc(2);
    check("no lock no ready", ready, 0);
    locked = 1'b1;
    wait_ready(t);
    check("lock to ready edges", t, 19);

    // Rates: 1/3 on ch0, 7/48 on ch1
    c0 = 0; c0_3k = 0; c1 = 0; first0 = -1; last1 = -1; gapbad = 0;
    for (int i = 1; i <= 4800; i++) begin
      cyc(1);
      if (ce[0]) begin
        c0++;
        if (i <= 3000) c0_3k++;
        if (first0 < 0) first0 = i;
      end
      if (ce[1]) begin
        if (last1 >= 0 && (i - last1) != 6 && (i - last1) != 7) gapbad++;
        last1 = i;
        c1++;
      end
    end
    check("ch0 first pulse edge", first0, 3);
    check("ch0 pulses in 3000", c0_3k, 1000);
    check("ch0 pulses in 4800", c0, 1600);
    check("ch1 pulses in 4800", c1, 700);
    check("ch1 bad gaps", gapbad, 0);

    // Lock loss mid-RUN and re-lock
    locked = 1'b0;
    cyc(2);
    check("ready before drop reaches fsm", ready, 1);
    cyc(1);
    check("ready after lock loss", ready, 0);
    check("ce after lock loss", ce, 0);
    cyc(2);
    locked = 1'b1;
    wait_ready(t);
    check("relock to ready edges", t, 19);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      pat[i] = ce[0];
    end
    check("ch0 phase after relock", pat, 6'b100100);

    // Load with new ch0 ratio 1/2
    set_ch(0, 1, 2);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("ce on load edge", ce, 0);
    check("ready on load edge", ready, 1);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      pat[i] = ce[0];
    end
    check("ch0 phase after load", pat, 6'b101010);

    // Corner ratios
    set_ch(0, 5, 0);
    set_ch(1, 5, 5);
    pulse_load();
    c0 = 0; c1 = 0;
    repeat (20) begin
      cyc(1);
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    check("mod=0 pulses", c0, 0);
    check("inc=mod pulses", c1, 20);
    set_ch(0, 0, 7);
    set_ch(1, 9, 5);
    pulse_load();
    c0 = 0; c1 = 0;
    repeat (20) begin
      cyc(1);
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    check("inc=0 pulses", c0, 0);
    check("inc>mod pulses", c1, 20);

    // Randomised ratios, loads and lock drops against the model
    for (int it = 0; it < 40; it++) begin
      act = int'($urandom_range(0, 3));
      case (act)
        0: begin
          rand_ch(0);
          rand_ch(1);
          pulse_load();
        end
        1: rand_ch(int'($urandom_range(0, 1)));
        2: begin
          locked = 1'b0;
          cyc(int'($urandom_range(1, 8)));
          locked = 1'b1;
        end
        default: if ($urandom_range(0, 1) == 1) pulse_load();
      endcase
      cyc(int'($urandom_range(5, 80)));
    end

    // Asynchronous reset mid-RUN
    set_ch(0, 1, 2);
    set_ch(1, 1, 1);
    locked = 1'b1;
    wait_ready(t);
    check("ready before async reset", ready, 1);
    cyc(2);
    #2 reset = 1'b0;
    #1;
    check("ready right after async reset", ready, 0);
    check("ce right after async reset", ce, 0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check("ready after reset release", ready, 0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
